// File: rtl/mem_pipe_ctrl.sv
// mem_pipe_ctrl: pipeline sequencing controller for the five-stage core.
//
// Drives the MEM-stage data-bus handshake (sram-like req / addr_ok / data_ok).
// It also derives the per-stage hold and bubble controls for the IF/ID, ID/EX,
// EX/MEM and MEM/WB segment registers. Hold/bubble sources are memory wait,
// divider busy, load-use hazard and MEM-stage exceptions. It keeps a saturating
// memory-stall counter and a sticky bus-timeout flag.
//
// Ports
//   clk, resetn        core clock, asynchronous active-low reset
//   mem_data_en        instruction in MEM needs a data access
//   mem_data_wen[3:0]  byte write enables (nonzero = store)
//   mem_ex             exception raised by the instruction in MEM
//   div_busy           EX-stage divider not finished
//   ex_load_use        ID depends on a load currently in EX
//   inst_busy          fetch side waiting on the instruction bus
//   data_addr_ok       data bus accepted the address
//   data_data_ok       data bus returned / acknowledged data
//   data_req, data_wr  data bus request and write qualifier
//   stall_if..mem      hold the corresponding segment register
//   flush_id..wb       load a bubble into that stage
//   exc_flush          exception commit pulse (PC redirect)
//   mem_rdata_vld      load data valid this cycle
//   stall_cnt          saturating count of memory-stall cycles
//   bus_err            sticky bus timeout
module mem_pipe_ctrl #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             mem_data_en,
  input  logic [3:0]       mem_data_wen,
  input  logic             mem_ex,
  input  logic             div_busy,
  input  logic             ex_load_use,
  input  logic             inst_busy,
  input  logic             data_addr_ok,
  input  logic             data_data_ok,
  output logic             data_req,
  output logic             data_wr,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic             exc_flush,
  output logic             mem_rdata_vld,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             bus_err
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } state_e;

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               in_idle, in_addr, in_data;
  logic               issue;
  logic               req_raw;
  logic               busy_raw;
  logic               exc_raw;
  logic [WaitW-1:0]   wait_inc;

  assign in_idle = (state_q == StIdle);
  assign in_addr = (state_q == StAddr);
  assign in_data = (state_q == StData);

  // A new access starts only from IDLE; an exception in MEM suppresses it.
  assign issue    = in_idle & mem_data_en & ~mem_ex;
  assign req_raw  = issue | in_addr;
  assign busy_raw = issue | in_addr | (in_data & ~data_data_ok);
  assign exc_raw  = in_idle & mem_ex;

  // Wait counter stops at TIMEOUT so it never wraps back below the threshold.
  assign wait_inc = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          wr_d    = |mem_data_wen;
          wait_d  = '0;
          state_d = data_addr_ok ? StData : StAddr;
        end
      end
      StAddr: begin
        wait_d = wait_inc;
        if (data_addr_ok) state_d = StData;
      end
      StData: begin
        // addr_ok is meaningless here since data_req is low.
        wait_d = wait_inc;
        if (data_data_ok) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // The FSM keeps waiting after a timeout; only the flag records it.
  assign bus_err_d = bus_err_q | ((in_addr | in_data) & (wait_d == WaitMax));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (busy_raw && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      wr_q        <= 1'b0;
      wait_q      <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      wait_q      <= wait_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Stall chain and bubbles. An exception commit overrides everything: every
  // segment advances and every stage receives a bubble. All combinational
  // outputs are gated by resetn so they read 0 while reset is held.
  always_comb begin
    logic s_mem, s_ex, s_id, s_if;
    s_mem = busy_raw;
    s_ex  = s_mem | div_busy;
    s_id  = s_ex | ex_load_use;
    s_if  = s_id | inst_busy;

    stall_mem = 1'b0;
    stall_ex  = 1'b0;
    stall_id  = 1'b0;
    stall_if  = 1'b0;
    flush_wb  = 1'b0;
    flush_mem = 1'b0;
    flush_ex  = 1'b0;
    flush_id  = 1'b0;

    if (resetn) begin
      if (exc_raw) begin
        flush_wb  = 1'b1;
        flush_mem = 1'b1;
        flush_ex  = 1'b1;
        flush_id  = 1'b1;
      end else begin
        stall_mem = s_mem;
        stall_ex  = s_ex;
        stall_id  = s_id;
        stall_if  = s_if;
        flush_wb  = s_mem;
        flush_mem = s_ex & ~s_mem;
        flush_ex  = s_id & ~s_ex;
        flush_id  = s_if & ~s_id;
      end
    end
  end

  assign data_req      = resetn & req_raw;
  assign data_wr       = resetn & req_raw & (|mem_data_wen);
  assign exc_flush     = resetn & exc_raw;
  assign mem_rdata_vld = resetn & in_data & data_data_ok & ~wr_q;
  assign stall_cnt     = stall_cnt_q;
  assign bus_err       = bus_err_q;

endmodule

// File: doc/mem_pipe_ctrl.md
Name: mem_pipe_ctrl

Overview:
- Pipeline sequencing controller for the five-stage core.
- Owns the MEM-stage data-bus handshake (sram-like req/addr_ok/data_ok).
- Generates per-stage stall and bubble (flush) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB segment registers, from memory wait, divider busy, load-use hazard and MEM-stage exceptions.
- Also keeps a saturating memory-stall counter and a sticky bus-timeout flag.

Parameters:
- CNT_W, 32, width of the memory-stall cycle counter.
- TIMEOUT, 1023, maximum cycles in ADDR/DATA before bus_err is set (must be >= 1).

Ports:
- clk  in  1  core clock.
- resetn  in  1  reset; asynchronous assert, active-low.
- mem_data_en  in  1  instruction in MEM needs a data access.
- mem_data_wen  in  4  byte write enables; nonzero means store.
- mem_ex  in  1  exception raised by the instruction in MEM.
- div_busy  in  1  EX-stage divider not finished.
- ex_load_use  in  1  ID needs the result of a load currently in EX.
- inst_busy  in  1  fetch side waiting on instruction bus.
- data_addr_ok  in  1  data bus accepted address.
- data_data_ok  in  1  data bus returned/acknowledged data.
- data_req  out  1  data bus request.
- data_wr  out  1  write request (= |mem_data_wen while data_req).
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the corresponding segment register.
- flush_id, flush_ex, flush_mem, flush_wb  out  1 each  load a bubble into that stage.
- exc_flush  out  1  exception commit pulse, used for PC redirect.
- mem_rdata_vld  out  1  load data valid this cycle.
- stall_cnt  out  CNT_W  memory-stall cycles.
- bus_err  out  1  sticky bus timeout.

Behaviour:
- Reset (resetn low, asynchronous):
  - State goes to IDLE; stall_cnt=0, bus_err=0, wait counter=0.
  - All outputs are forced to 0 while resetn is low, including the combinational ones.
  - A reset in ADDR or DATA abandons the transaction; no response is expected afterwards.
- FSM, states IDLE, ADDR, DATA:
  - IDLE:
    - If mem_data_en && !mem_ex: data_req=1 (Mealy, same cycle).
    - addr_ok=1 -> DATA; otherwise -> ADDR.
    - Otherwise stay in IDLE.
  - ADDR:
    - data_req=1, held steady until addr_ok; -> DATA on addr_ok.
    - mem_ex is ignored here because the request cannot be withdrawn.
  - DATA:
    - data_req=0.
    - data_ok -> IDLE. In that same cycle mem_busy deasserts and mem_rdata_vld = !data_wr_latched.
- Derived busy signal:
  - mem_busy = (IDLE && mem_data_en && !mem_ex) || ADDR || (DATA && !data_ok).
- Latency: minimum access is 2 cycles (addr_ok in the IDLE cycle, data_ok in the next cycle).
- data_wr:
  - Registered at issue as data_wr_latched.
  - Driven combinationally as |mem_data_wen whenever data_req=1.
- Stall chain:
  - stall_mem = mem_busy
  - stall_ex = stall_mem | div_busy
  - stall_id = stall_ex | ex_load_use
  - stall_if = stall_id | inst_busy
- Bubbles (downstream stage advances while upstream holds):
  - flush_wb = stall_mem
  - flush_mem = stall_ex & !stall_mem
  - flush_ex = stall_id & !stall_ex
  - flush_id = stall_if & !stall_id
- Exception handling:
  - exc_flush = mem_ex && state==IDLE.
  - When exc_flush=1: all stall_* = 0 and flush_id/ex/mem/wb = 1. This overrides everything above.
  - An exception together with mem_data_en issues no request.
- Counters:
  - stall_cnt increments every cycle mem_busy=1 and saturates at all-ones.
  - The wait counter resets on entering ADDR from IDLE and increments each cycle in ADDR or DATA.
  - bus_err is set when the wait counter reaches TIMEOUT and stays set until reset. The FSM keeps waiting.
- Simultaneous events:
  - addr_ok and data_ok in the same DATA cycle: data_ok wins (addr_ok is meaningless when data_req=0).
  - div_busy and mem_busy together: both EX and MEM hold, and flush_wb=1.

Test Plan:
- Load, addr_ok in cycle 0, data_ok in cycle 3:
  - data_req=1 in cycles 0 only; stall_mem=1 in cycles 0-2; in cycle 3 stall_mem=0 and mem_rdata_vld=1.
  - stall_cnt goes 0->3; flush_wb=1 in cycles 0-2.
- Store with mem_data_wen=4'b0011, addr_ok delayed 2 cycles:
  - data_req and data_wr held at 1 for cycles 0-2 with no drop; mem_rdata_vld stays 0 on data_ok.
- div_busy=1 for 4 cycles, no memory activity:
  - stall_if/id/ex=1, stall_mem=0, flush_mem=1 for 4 cycles.
  - ex_load_use alone gives flush_ex=1 and stall_ex=0.
- mem_ex=1 with mem_data_en=1 in IDLE:
  - data_req=0, exc_flush=1, all flush_*=1, all stall_*=0.
  - The same mem_ex while in DATA is ignored until data_ok.
- TIMEOUT=8, data_ok never returns:
  - bus_err rises after 8 cycles in ADDR/DATA and stays 1.
  - Asserting resetn=0 mid-DATA clears bus_err, stall_cnt and state immediately, without waiting for a clock edge.
- CNT_W=4 with a 20-cycle memory wait: stall_cnt saturates at 15.
